result_collector: RTL
=====================

// Module: result_collector
// PURPOSE
// - Consumer at the far end of the matrix multiplier's result stream (valid/result/done).
// - Captures the d0 x d2 product matrix, row-major, into an internal C buffer of 2^m words.
// - Signals completion when all elements have arrived.
// - Gives the host a registered, random-access read port into the buffer.
// - Flags protocol violations: short stream, extra data, oversize dimensions.
// PARAMETERS
// - n  8   element width; result words are 2*n bits.
// - m  10  buffer address width; capacity is 2^m words.
// PORTS
// - clk       in   1     system clock, rising edge
// - rst       in   1     asynchronous reset, active-low (asserted at 0)
// - start     in   1     one-cycle pulse; latch dimensions and arm collection
// - d0        in   n     rows of the result; sampled on start
// - d2        in   n     columns of the result; sampled on start
// - valid     in   1     result word present this cycle
// - result    in   2*n   result word
// - mm_done   in   1     multiplier completion pulse
// - rd_en     in   1     host read request
// - rd_adr    in   m     host read address (row-major index)
// - rd_data   out  2*n   registered read data
// - rd_valid  out  1     rd_data holds a captured element
// - count     out  m+1   number of elements captured so far
// - busy      out  1     high during collection
// - done      out  1     level; all d0*d2 elements captured
// - err       out  3     sticky error flags: {oversize, extra, short}
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE; all outputs 0, including rd_data.
//   - Buffer contents are not cleared.
// - Dimension capture: total = d0*d2 is computed at 2n bits and registered on start.
// - FSM states:
//   - IDLE -> ARM on start.
//   - ARM (1 cycle): if total==0 or total>2^m, set err[2] and go to READY with done=1, count=0.
//     Otherwise go to COLLECT.
//   - COLLECT, each cycle with valid=1:
//     - mem[wadr] <= result; wadr++; count++.
//     - The write that makes count==total goes to READY; done rises the next cycle.
//   - COLLECT with mm_done=1 and count<total (not counting a same-cycle final write):
//     set err[0], go to READY, done=1.
//   - READY -> ARM on start.
// - start in any state:
//   - Restarts collection and clears wadr, count, done.
//   - err is cleared only by reset or by start.
//   - start has priority over a same-cycle valid; that word is dropped.
// - valid outside COLLECT:
//   - In READY: set err[1]; no write.
//   - In IDLE or ARM: ignored.
// - busy = (state==ARM || state==COLLECT).
// - Read port, latency 1, legal in every state:
//   - rd_data <= mem[rd_adr] when rd_en=1.
//   - rd_valid <= rd_en && (rd_adr < count).
//   - Reading the address being written in the same cycle returns the old contents.
//   - rd_valid=0 and rd_data holds its value when rd_en=0.
// - Full boundary: total==2^m is legal.
//   - wadr wraps to 0 after the last write; count reaches 2^m (width m+1, so no wrap).
// - No backpressure; the block accepts one word per cycle indefinitely.
// STRUCTURE
// - Shared package or header (with the other matrix-mult blocks):
//   - state encodings IDLE/ARM/COLLECT/READY;
//   - error bit indices ERR_SHORT=0, ERR_EXTRA=1, ERR_OVERSIZE=2.
// - One sub-module, result_ram: 2^m x 2*n, one synchronous write port, one registered read port.
// - FSM, counters and error logic stay in result_collector.
// TESTING
// - Full run: d0=2, d2=3, start, six valid words 0x0011..0x0016 on consecutive cycles
//   -> count=6, done=1 one cycle after the 6th word, err=0.
//   Then read addresses 0..5 -> rd_data 0x0011..0x0016 with rd_valid=1, one cycle after each rd_en.
// - Gapped stream: the same six words with 1-3 idle cycles between them -> same buffer contents.
//   busy stays 1 until the 6th word.
// - Short stream: d0=2, d2=3, four words then mm_done -> done=1, count=4, err=3'b001.
//   Reading address 5 -> rd_valid=0.
// - Extra data: after a complete run, one more valid word -> err=3'b010, count stays 6.
//   mem[0] is unchanged.
// - Oversize and zero:
//   - d0=40, d2=40 (1600 > 1024) -> err=3'b100, done=1 two cycles after start, no writes.
//   - d0=0 -> same response.
// - Disruption:
//   - Reset mid-COLLECT after 3 words -> all outputs 0 immediately (asynchronous).
//   - start mid-COLLECT -> count=0, and the new run overwrites from address 0.

Source files
------------

// File: rtl/result_collector_pkg.sv
// Shared definitions for the matrix-multiplier result path: FSM states,
// error-flag bit positions and default geometry.
package result_collector_pkg;

  localparam int N_DEFAULT = 8;
  localparam int M_DEFAULT = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    COLLECT = 2'd2,
    READY   = 2'd3
  } state_e;

  localparam int ERR_SHORT    = 0;
  localparam int ERR_EXTRA    = 1;
  localparam int ERR_OVERSIZE = 2;

  function automatic logic [2:0] err_mask(input int idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/result_collector_if.sv
// Bundle of the result-stream inputs, host read port and status outputs of
// the result collector. master = multiplier/host side, slave = collector.
interface result_collector_if #(
  parameter int N = 8,
  parameter int M = 10
);
  logic             start;
  logic [N-1:0]     d0;
  logic [N-1:0]     d2;
  logic             valid;
  logic [2*N-1:0]   result;
  logic             mm_done;
  logic             rd_en;
  logic [M-1:0]     rd_adr;
  logic [2*N-1:0]   rd_data;
  logic             rd_valid;
  logic [M:0]       count;
  logic             busy;
  logic             done;
  logic [2:0]       err;

  modport master (
    output start, d0, d2, valid, result, mm_done, rd_en, rd_adr,
    input  rd_data, rd_valid, count, busy, done, err
  );

  modport slave (
    input  start, d0, d2, valid, result, mm_done, rd_en, rd_adr,
    output rd_data, rd_valid, count, busy, done, err
  );
endinterface

// File: rtl/result_collector_ram.sv
// C buffer: 2^AW words, one synchronous write port and a registered read
// port that returns the pre-write contents on a same-address collision.
module result_ram #(
  parameter int W  = 16,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] wadr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] radr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem [2**AW];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[wadr_i] <= wdata_i;
  end

  // Only the output register is reset; the array itself keeps its contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      rdata_q <= '0;
    else if (re_i) rdata_q <= mem[radr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/result_collector.sv
// Captures a d0 x d2 result stream row-major into a local buffer, reports
// completion and protocol errors, and serves host reads with latency 1.
module result_collector
  import result_collector_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int M = M_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  result_collector_if.slave bus
);

  localparam logic [31:0] CAP = 32'(1) << M;

  state_e           state_q, state_d;
  logic [2*N-1:0]   total_q, total_d;
  logic [M-1:0]     wadr_q, wadr_d;
  logic [M:0]       count_q, count_d;
  logic             done_q, done_d;
  logic [2:0]       err_q, err_d;
  logic             rd_valid_q;
  logic             we;
  logic [2*N-1:0]   total_new;
  logic             bad_dims;
  logic             final_wr;

  assign total_new = {{N{1'b0}}, bus.d0} * {{N{1'b0}}, bus.d2};
  assign bad_dims  = (total_q == '0) || (32'(total_q) > CAP);
  assign final_wr  = (32'(count_q) + 32'd1) == 32'(total_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      total_q    <= '0;
      wadr_q     <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      wadr_q     <= wadr_d;
      count_q    <= count_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rd_valid_q <= bus.rd_en && ({1'b0, bus.rd_adr} < count_q);
    end
  end

  always_comb begin
    state_d = state_q;
    total_d = total_q;
    wadr_d  = wadr_q;
    count_d = count_q;
    done_d  = done_q;
    err_d   = err_q;
    we      = 1'b0;

    // start wins over everything, including a same-cycle valid word.
    if (bus.start) begin
      state_d = ARM;
      total_d = total_new;
      wadr_d  = '0;
      count_d = '0;
      done_d  = 1'b0;
      err_d   = '0;
    end else begin
      case (state_q)
        IDLE: ;
        ARM: begin
          if (bad_dims) begin
            err_d   = err_q | err_mask(ERR_OVERSIZE);
            state_d = READY;
            done_d  = 1'b1;
          end else begin
            state_d = COLLECT;
          end
        end
        COLLECT: begin
          if (bus.valid) begin
            we      = 1'b1;
            wadr_d  = wadr_q + 1'b1;
            count_d = count_q + 1'b1;
          end
          if (bus.valid && final_wr) begin
            state_d = READY;
            done_d  = 1'b1;
          end else if (bus.mm_done) begin
            err_d   = err_q | err_mask(ERR_SHORT);
            state_d = READY;
            done_d  = 1'b1;
          end
        end
        READY: begin
          if (bus.valid) err_d = err_q | err_mask(ERR_EXTRA);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  result_ram #(
    .W  (2*N),
    .AW (M)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we),
    .wadr_i  (wadr_q),
    .wdata_i (bus.result),
    .re_i    (bus.rd_en),
    .radr_i  (bus.rd_adr),
    .rdata_o (bus.rd_data)
  );

  assign bus.rd_valid = rd_valid_q;
  assign bus.count    = count_q;
  assign bus.busy     = (state_q == ARM) || (state_q == COLLECT);
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule
